// File: rtl/sdram_arbiter_pkg.sv
// Shared command encoding and FSM state type for the SDRAM port arbiter.
package sdram_arbiter_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module round_robin_picker #(
    parameter int NUM_PORTS = 3
) (
    input  logic [NUM_PORTS-1:0]         request,
    input  logic [$clog2(NUM_PORTS)-1:0] pointer,
    output logic [NUM_PORTS-1:0]         grant,
    output logic                         valid
);

    localparam int PW  = $clog2(NUM_PORTS);
    localparam int PW1 = PW + 1;

    // Scan from the farthest offset down so the closest requester is written last.
    always_comb begin
        logic [PW:0] idx;
        idx   = '0;
        grant = '0;
        valid = 1'b0;
        for (int off = NUM_PORTS - 1; off >= 0; off--) begin
            idx = {1'b0, pointer} + PW1'(off);
            if (idx >= PW1'(NUM_PORTS)) begin
                idx = idx - PW1'(NUM_PORTS);
            end
            if (request[idx[PW-1:0]]) begin
                grant              = '0;
                grant[idx[PW-1:0]] = 1'b1;
                valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Burst arbiter between frame-buffer client ports and an SDRAM controller.
// Optional SDRAM_ARBITER_READ_PRIORITY_EN: requesting read ports always beat write ports.
//
// state  | meaning
// IDLE   | no burst; grant the next requesting port (command 0)
// WRITE  | streaming BURST_LENGTH words from the granted write port (command 1)
// READ   | streaming BURST_LENGTH words into the granted read port (command 2)
module sdram_port_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int                       NUM_PORTS     = 3,
    parameter int                       BURST_LENGTH  = 8,
    parameter int                       ADDRESS_WIDTH = 22,
    parameter logic [NUM_PORTS-1:0]     PORT_IS_READ  = 3'b010,
    parameter logic [ADDRESS_WIDTH-1:0] FRAME_BASE [NUM_PORTS] = '{default: '0},
    parameter logic [ADDRESS_WIDTH-1:0] FRAME_END  [NUM_PORTS] =
        '{default: ADDRESS_WIDTH'((640 * 480) / 2)}
) (
    input  logic                          sdram_clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          port_request,
    input  logic [NUM_PORTS-1:0]          port_frame_sync,
    input  logic [NUM_PORTS-1:0][15:0]    port_write_data,
    output logic [NUM_PORTS-1:0]          port_write_acknowledge,
    output logic [NUM_PORTS-1:0]          port_read_valid,
    output logic [15:0]                   read_data,
    output logic [1:0]                    command,
    output logic [ADDRESS_WIDTH-1:0]      data_address,
    output logic [15:0]                   data_write,
    input  logic [15:0]                   data_read,
    input  logic                          data_read_valid,
    input  logic                          data_write_done
);

    localparam int PW  = $clog2(NUM_PORTS);
    localparam int BW  = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
    localparam int AW1 = ADDRESS_WIDTH + 1;
    localparam logic [BW-1:0]  LAST_BEAT  = BW'(BURST_LENGTH - 1);
    localparam logic [AW1-1:0] BURST_STEP = AW1'(BURST_LENGTH);

    arb_state_t                state, state_next;
    logic [PW-1:0]             granted;
    logic [PW-1:0]             rr_pointer;
    logic [BW-1:0]             beat_count;
    logic [ADDRESS_WIDTH-1:0]  port_address [NUM_PORTS];
    logic [ADDRESS_WIDTH-1:0]  address_next [NUM_PORTS];
    logic [NUM_PORTS-1:0]      sync_pending;
    logic [NUM_PORTS-1:0]      pick_request;
    logic [NUM_PORTS-1:0]      pick_grant;
    logic                      pick_valid;
    logic [PW-1:0]             pick_index;
    logic [NUM_PORTS-1:0]      port_busy;
    logic                      beat;
    logic                      burst_done;
    logic                      grant_now;

`ifdef SDRAM_ARBITER_READ_PRIORITY_EN
    always_comb begin
        if (|(port_request & PORT_IS_READ)) begin
            pick_request = port_request & PORT_IS_READ;
        end else begin
            pick_request = port_request & ~PORT_IS_READ;
        end
    end
`else
    assign pick_request = port_request;
`endif

    round_robin_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .request (pick_request),
        .pointer (rr_pointer),
        .grant   (pick_grant),
        .valid   (pick_valid)
    );

    always_comb begin
        pick_index = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pick_grant[i]) begin
                pick_index = PW'(i);
            end
        end
    end

    assign grant_now  = (state == ST_IDLE) && pick_valid;
    assign beat       = ((state == ST_WRITE) && data_write_done) ||
                        ((state == ST_READ) && data_read_valid);
    assign burst_done = beat && (beat_count == LAST_BEAT);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_next = PORT_IS_READ[pick_index] ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE, ST_READ: begin
                if (burst_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        case (state)
            ST_WRITE: command = CMD_WRITE;
            ST_READ:  command = CMD_READ;
            default:  command = CMD_IDLE;
        endcase
    end

    always_comb begin
        port_write_acknowledge          = '0;
        port_read_valid                 = '0;
        port_write_acknowledge[granted] = (state == ST_WRITE) && data_write_done;
        port_read_valid[granted]        = (state == ST_READ) && data_read_valid;
    end

    assign data_write = port_write_data[granted];
    assign read_data  = data_read;

    // A port being granted this cycle counts as busy so its sync waits for burst end.
    always_comb begin
        logic [AW1-1:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            sum             = {1'b0, port_address[i]} + BURST_STEP;
            address_next[i] = (sum == {1'b0, FRAME_END[i]}) ? FRAME_BASE[i]
                                                            : sum[ADDRESS_WIDTH-1:0];
            port_busy[i]    = ((state != ST_IDLE) && (granted == PW'(i))) ||
                              (grant_now && pick_grant[i]);
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            granted      <= '0;
            rr_pointer   <= '0;
            beat_count   <= '0;
            data_address <= '0;
            sync_pending <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                port_address[i] <= FRAME_BASE[i];
            end
        end else begin
            state <= state_next;
            if (grant_now) begin
                granted      <= pick_index;
                rr_pointer   <= (pick_index == PW'(NUM_PORTS - 1)) ? '0 : pick_index + PW'(1);
                data_address <= port_address[pick_index];
                beat_count   <= '0;
            end else if (beat) begin
                beat_count <= burst_done ? '0 : beat_count + BW'(1);
            end
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (burst_done && (granted == PW'(i))) begin
                    port_address[i] <= (sync_pending[i] || port_frame_sync[i]) ? FRAME_BASE[i]
                                                                               : address_next[i];
                    sync_pending[i] <= 1'b0;
                end else if (port_frame_sync[i]) begin
                    if (port_busy[i]) begin
                        sync_pending[i] <= 1'b1;
                    end else begin
                        port_address[i] <= FRAME_BASE[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: expected grants queued by stimulus, checked by a monitor.
module tb_sdram_port_arbiter;

    localparam int BL = 8;
    localparam logic [21:0] TB_BASE [3] = '{22'd0, 22'd0, 22'd0};
    localparam logic [21:0] TB_END  [3] = '{22'd153600, 22'd24, 22'd153600};

    logic             sdram_clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       port_request = '0;
    logic [2:0]       port_frame_sync = '0;
    logic [2:0][15:0] port_write_data;
    logic [2:0]       port_write_acknowledge;
    logic [2:0]       port_read_valid;
    logic [15:0]      read_data;
    logic [1:0]       command;
    logic [21:0]      data_address;
    logic [15:0]      data_write;
    logic [15:0]      data_read = '0;
    logic             data_read_valid = 1'b0;
    logic             data_write_done = 1'b0;

    sdram_port_arbiter #(
        .NUM_PORTS     (3),
        .BURST_LENGTH  (BL),
        .ADDRESS_WIDTH (22),
        .PORT_IS_READ  (3'b010),
        .FRAME_BASE    (TB_BASE),
        .FRAME_END     (TB_END)
    ) dut (
        .sdram_clk              (sdram_clk),
        .reset                  (reset),
        .port_request           (port_request),
        .port_frame_sync        (port_frame_sync),
        .port_write_data        (port_write_data),
        .port_write_acknowledge (port_write_acknowledge),
        .port_read_valid        (port_read_valid),
        .read_data              (read_data),
        .command                (command),
        .data_address           (data_address),
        .data_write             (data_write),
        .data_read              (data_read),
        .data_read_valid        (data_read_valid),
        .data_write_done        (data_write_done)
    );

    always #5 sdram_clk = ~sdram_clk;

    typedef struct {
        int          port;
        logic [1:0]  cmd;
        logic [21:0] addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   starts = 0;
    int   ends   = 0;
    int   beats  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int p, input logic [21:0] a);
        exp_t e;
        e.port = p;
        e.cmd  = (p == 1) ? 2'd2 : 2'd1;
        e.addr = a;
        sb.push_back(e);
    endtask

    // Controller model: accepts/returns words while a command is up, stalling every third cycle.
    initial begin
        int cyc = 0;
        forever begin
            @(posedge sdram_clk);
            #1;
            cyc++;
            data_write_done = (command == 2'd1) && (cyc % 3 != 0);
            data_read_valid = (command == 2'd2) && (cyc % 3 != 0);
            data_read       = 16'hA000 + 16'(cyc);
        end
    end

    // Monitor: pops an expectation at each burst start and checks every beat of the burst.
    initial begin
        logic [1:0]  prev_cmd = 2'd0;
        int          cur_port = 0;
        logic [21:0] cur_addr = '0;
        exp_t        e;
        forever begin
            @(negedge sdram_clk);
            if (reset) begin
                prev_cmd = 2'd0;
            end else begin
                if (command != 2'd0 && prev_cmd == 2'd0) begin
                    starts++;
                    beats = 0;
                    if (sb.size() == 0) begin
                        check("unexpected_grant", 32'(command), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("burst_command", 32'(command), 32'(e.cmd));
                        check("burst_address", 32'(data_address), 32'(e.addr));
                        cur_port = e.port;
                        cur_addr = e.addr;
                    end
                end
                if (command != 2'd0) begin
                    check("address_stable", 32'(data_address), 32'(cur_addr));
                    if (command == 2'd1 && data_write_done) begin
                        beats++;
                        check("write_ack", 32'(port_write_acknowledge), 32'(3'b001 << cur_port));
                        check("write_data", 32'(data_write), 32'(16'h1111 * (cur_port + 1)));
                    end else if (command == 2'd2 && data_read_valid) begin
                        beats++;
                        check("read_valid", 32'(port_read_valid), 32'(3'b001 << cur_port));
                        check("read_data", 32'(read_data), 32'(data_read));
                    end else begin
                        check("stall_strobes", 32'({port_write_acknowledge, port_read_valid}), 32'd0);
                    end
                end else begin
                    check("idle_strobes", 32'({port_write_acknowledge, port_read_valid}), 32'd0);
                    if (prev_cmd != 2'd0) begin
                        ends++;
                        check("burst_beats", 32'(beats), 32'(BL));
                    end
                end
                prev_cmd = command;
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge sdram_clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic run_bursts(input logic [2:0] mask, input int n);
        int s_target = starts + n;
        int e_target = ends + n;
        int t = 0;
        port_request = mask;
        while (starts < s_target && t < 2000) begin
            @(posedge sdram_clk);
            #2;
            t++;
        end
        port_request = '0;
        while (ends < e_target && t < 2000) begin
            @(posedge sdram_clk);
            #2;
            t++;
        end
        if (t >= 2000) check("burst_timeout", 32'(t), 32'd0);
        @(posedge sdram_clk);
        #2;
    endtask

    task automatic wait_beats(input int s_target, input int b);
        int t = 0;
        while (!(starts >= s_target && beats >= b) && t < 2000) begin
            @(posedge sdram_clk);
            #2;
            t++;
        end
        if (t >= 2000) check("beat_timeout", 32'(t), 32'd0);
    endtask

    initial begin
        int s0;
        port_write_data = {16'h3333, 16'h2222, 16'h1111};
        apply_reset();
        @(negedge sdram_clk);
        check("reset_command", 32'(command), 32'd0);
        check("reset_address", 32'(data_address), 32'd0);
        check("reset_ack", 32'(port_write_acknowledge), 32'd0);
        check("reset_read_valid", 32'(port_read_valid), 32'd0);

        // single write port: consecutive bursts at 0 then 8
        push(0, 22'd0);
        push(0, 22'd8);
        run_bursts(3'b001, 2);

        // all ports requesting
        apply_reset();
`ifdef SDRAM_ARBITER_READ_PRIORITY_EN
        push(1, 22'd0);
        push(1, 22'd8);
        push(1, 22'd16);
        push(1, 22'd0);
`else
        push(0, 22'd0);
        push(1, 22'd0);
        push(2, 22'd0);
        push(0, 22'd8);
`endif
        run_bursts(3'b111, 4);

        // read port wraps at its window end (24)
        apply_reset();
        push(1, 22'd0);
        push(1, 22'd8);
        push(1, 22'd16);
        push(1, 22'd0);
        run_bursts(3'b010, 4);

        // frame sync during port 0's beat 3: burst completes, next burst restarts at base
        apply_reset();
        push(0, 22'd0);
        push(0, 22'd8);
        push(0, 22'd0);
        s0 = starts;
        port_request = 3'b001;
        wait_beats(s0 + 2, 3);
        port_frame_sync = 3'b001;
        @(posedge sdram_clk);
        #2;
        port_frame_sync = '0;
        run_bursts(3'b001, 1);

        // frame sync on an idle port takes effect immediately (port 0 sits at 8)
        port_frame_sync = 3'b001;
        @(posedge sdram_clk);
        #2;
        port_frame_sync = '0;
        push(0, 22'd0);
        run_bursts(3'b001, 1);

        // reset at beat 4 of a read burst abandons it
        apply_reset();
        push(1, 22'd0);
        push(1, 22'd8);
        run_bursts(3'b010, 1);
        s0 = starts;
        port_request = 3'b010;
        wait_beats(s0 + 1, 4);
        port_request = '0;
        reset = 1'b1;
        @(posedge sdram_clk);
        @(negedge sdram_clk);
        check("abort_command", 32'(command), 32'd0);
        check("abort_read_valid", 32'(port_read_valid), 32'd0);
        check("abort_address", 32'(data_address), 32'd0);
        @(posedge sdram_clk);
        #2;
        reset = 1'b0;
        push(1, 22'd0);
        run_bursts(3'b010, 1);

        repeat (4) @(posedge sdram_clk);
        #2;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
